// File: rtl/uart_tx_fifo.sv
// UART transmitter draining a show-ahead FIFO: pops a word, sends start,
// data LSB first, optional parity, stop bit(s); back-to-back with no gap.
// Ports: clk_i, rst_i (sync, active high), tx_en_i, fifo_data_i,
//   fifo_empty_i, fifo_rd_en_o (pop strobe), tx_o (serial), busy_o.
module uart_tx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 tx_en_i,
  input  logic [DATA_BITS-1:0] fifo_data_i,
  input  logic                 fifo_empty_i,
  output logic                 fifo_rd_en_o,
  output logic                 tx_o,
  output logic                 busy_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] D_LAST  = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] S_LAST  = IW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 bit_end;
  logic                 last_stop;
  logic                 pop;
  logic                 par_calc;

  assign bit_end   = (cnt_q == CNT_MAX);
  assign last_stop = (state_q == S_STOP) & bit_end & (idx_q == S_LAST);
  assign pop       = ~rst_i & tx_en_i & ~fifo_empty_i &
                     ((state_q == S_IDLE) | last_stop);
  assign par_calc  = (PARITY == 1) ? ~^fifo_data_i : ^fifo_data_i;

  assign fifo_rd_en_o = pop;
  assign tx_o         = tx_q;
  assign busy_o       = (state_q != S_IDLE) & ~rst_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == S_IDLE || bit_end) ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    sh_d    = sh_q;
    par_d   = par_q;
    tx_d    = tx_q;
    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (pop) begin
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
          tx_d    = sh_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          sh_d  = sh_q >> 1;
          tx_d  = sh_q[1];
          idx_d = idx_q + 1'b1;
          if (idx_q == D_LAST) begin
            idx_d = '0;
            if (PARITY != 0) begin
              state_d = S_PAR;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end
        end
      end
      S_PAR: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (idx_q == S_LAST) begin
            // Next frame starts straight out of the stop bit if a word waits.
            state_d = pop ? S_START : S_IDLE;
            tx_d    = ~pop;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
    if (pop) begin
      sh_d  = fifo_data_i;
      par_d = par_calc;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances (no/odd/even parity, 1/1/2 stops)
// checked cycle by cycle against a frame-position model, plus literals.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] fdata [3];
  logic [2:0] fempty;
  logic [2:0] rd;
  logic [2:0] txo;
  logic [2:0] busy;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_tx_fifo #(
      .DATA_BITS   (8),
      .CLKS_PER_BIT(4),
      .PARITY      (g),
      .STOP_BITS   ((g == 2) ? 2 : 1)
    ) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .tx_en_i     (en),
      .fifo_data_i (fdata[g]),
      .fifo_empty_i(fempty[g]),
      .fifo_rd_en_o(rd[g]),
      .tx_o        (txo[g]),
      .busy_o      (busy[g])
    );
  end

  int total = 0;
  int bad   = 0;

  // Upstream FIFO contents per instance.
  logic [7:0] mem [3][256];
  int wp [3];
  int rp [3];

  // Model: frame active, cycle position within frame, word being sent.
  logic       act  [3];
  int         pos  [3];
  logic [7:0] word [3];

  logic chk_on = 1'b0;
  logic rec    = 1'b0;
  int   busycnt [3];
  int   rdcnt   [3];
  int   drops   [3];
  logic prevb   [3];
  logic cap     [3][128];

  function automatic int flen(int i);
    return (1 + 8 + ((i != 0) ? 1 : 0) + ((i == 2) ? 2 : 1)) * 4;
  endfunction

  function automatic logic model_pop(int i);
    return !rst && en && (wp[i] != rp[i]) &&
           (!act[i] || pos[i] == flen(i) - 1);
  endfunction

  function automatic logic exp_tx(int i);
    int b;
    logic [7:0] w;
    b = pos[i] / 4;
    w = word[i];
    if (b == 0) return 1'b0;
    if (b <= 8) return w[b-1];
    if (i != 0 && b == 9) return (i == 1) ? ~^w : ^w;
    return 1'b1;
  endfunction

  task automatic chk(string nm, int i, logic got, logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s[%0d] got=%b want=%b t=%0t", nm, i, got, want,
               $time);
    end
  endtask

  task automatic lit(string nm, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 3; i++) begin
        chk("rd_en", i, rd[i], model_pop(i));
        chk("tx", i, txo[i], act[i] ? exp_tx(i) : 1'b1);
        chk("busy", i, busy[i], act[i] && !rst);
      end
    end
    if (rec) begin
      for (int i = 0; i < 3; i++) begin
        if (busy[i] === 1'b1) begin
          if (busycnt[i] < 128) cap[i][busycnt[i]] = txo[i];
          busycnt[i]++;
        end
        if (rd[i] === 1'b1) rdcnt[i]++;
        if (prevb[i] === 1'b1 && busy[i] !== 1'b1) drops[i]++;
        prevb[i] = busy[i];
      end
    end
  end

  task automatic drive_fifo();
    for (int i = 0; i < 3; i++) begin
      fempty[i] = (wp[i] == rp[i]);
      fdata[i]  = fempty[i] ? 8'($urandom) : mem[i][rp[i] % 256];
    end
  endtask

  task automatic push(int i, logic [7:0] d);
    mem[i][wp[i] % 256] = d;
    wp[i]++;
    drive_fifo();
  endtask

  task automatic update();
    logic p;
    for (int i = 0; i < 3; i++) begin
      p = model_pop(i);
      if (rst) begin
        act[i] = 1'b0;
      end else begin
        if (act[i]) begin
          pos[i]++;
          if (pos[i] == flen(i)) act[i] = 1'b0;
        end
        if (p) begin
          word[i] = mem[i][rp[i] % 256];
          rp[i]++;
          act[i] = 1'b1;
          pos[i] = 0;
        end
      end
    end
  endtask

  task automatic cyc(int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      update();
      #1;
      drive_fifo();
    end
  endtask

  task automatic rec_start();
    for (int i = 0; i < 3; i++) begin
      busycnt[i] = 0;
      rdcnt[i]   = 0;
      drops[i]   = 0;
      prevb[i]   = 1'b0;
    end
    rec = 1'b1;
  endtask

  int exp0 [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wp[i] = 0; rp[i] = 0; act[i] = 1'b0; pos[i] = 0; word[i] = '0;
    end
    drive_fifo();
    cyc(1);
    chk_on = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(2);

    // Single words: 0xA5 without parity, 0x07 with odd and even parity.
    en = 1'b1;
    rec_start();
    push(0, 8'hA5);
    push(1, 8'h07);
    push(2, 8'h07);
    cyc(60);
    rec = 1'b0;
    lit("busy_len_p0", busycnt[0], 40);
    lit("busy_len_odd", busycnt[1], 44);
    lit("busy_len_even2stop", busycnt[2], 48);
    lit("rd_pulses_p0", rdcnt[0], 1);
    for (int b = 0; b < 10; b++)
      lit($sformatf("a5_bit%0d", b), int'(cap[0][4*b+1]), exp0[b]);
    lit("odd_par_07", int'(cap[1][37]), 0);
    lit("even_par_07", int'(cap[2][37]), 1);
    lit("second_stop", int'(cap[2][45]), 1);

    // Back-to-back frames.
    rec_start();
    push(0, 8'h00);
    push(0, 8'hFF);
    cyc(100);
    rec = 1'b0;
    lit("b2b_busy", busycnt[0], 80);
    lit("b2b_rd", rdcnt[0], 2);
    lit("b2b_drops", drops[0], 1);

    // Empty FIFO, then disabled with data waiting.
    rec_start();
    cyc(100);
    en = 1'b0;
    push(0, 8'h5A);
    push(1, 8'h3C);
    cyc(100);
    rec = 1'b0;
    lit("idle_rd", rdcnt[0] + rdcnt[1] + rdcnt[2], 0);
    lit("idle_busy", busycnt[0] + busycnt[1] + busycnt[2], 0);
    en = 1'b1;
    cyc(60);

    // Disable during data bit 3 with a second word pending.
    rec_start();
    push(0, 8'h3C);
    push(0, 8'hC3);
    cyc(18);
    en = 1'b0;
    cyc(80);
    rec = 1'b0;
    lit("dis_rd", rdcnt[0], 1);
    lit("dis_busy", busycnt[0], 40);
    en = 1'b1;
    cyc(60);

    // Reset during data: aborted word is lost, next word goes at once.
    push(0, 8'h11);
    push(0, 8'h22);
    cyc(20);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    rec_start();
    cyc(60);
    rec = 1'b0;
    lit("rst_rd", rdcnt[0], 1);
    lit("rst_busy", busycnt[0], 40);
    lit("rst_word_bit1", int'(cap[0][9]), 1);

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 399) == 0);
      en  = ($urandom_range(0, 15) != 0);
      for (int i = 0; i < 3; i++)
        if (wp[i] - rp[i] < 8 && $urandom_range(0, 29) == 0)
          push(i, 8'($urandom));
      cyc(1);
    end
    rst = 1'b0;
    en  = 1'b1;
    cyc(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (legal 5..9; equals the width of the upstream FIFO).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, meaning clock cycles per serial bit (legal >= 2).
REQ-003 SHALL have parameter PARITY, default 0, meaning 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame (legal 1 or 2).
REQ-005 SHALL have port clk_i, input, 1, sole clock; all state on rising edge.
REQ-006 SHALL have port rst_i, input, 1, reset, synchronous and active-high.
REQ-007 SHALL have port tx_en_i, input, 1, permits starting new frames.
REQ-008 SHALL have port fifo_data_i, input, DATA_BITS, upstream FIFO head word, show-ahead (valid whenever fifo_empty_i=0).
REQ-009 SHALL have port fifo_empty_i, input, 1, upstream FIFO empty flag.
REQ-010 SHALL have port fifo_rd_en_o, output, 1, pop strobe to the upstream FIFO.
REQ-011 SHALL have port tx_o, output, 1, serial line, registered, idle high.
REQ-012 SHALL have port busy_o, output, 1, high while a frame is on the line.

Function
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY=0.
REQ-014 SHALL make the pop condition "pop" = tx_en_i & ~fifo_empty_i & (state==IDLE | last cycle of last STOP bit).
REQ-015 SHALL drive fifo_rd_en_o = pop combinationally, giving exactly one cycle per word and never asserting it while fifo_empty_i=1.
REQ-016 SHALL, in the pop cycle, latch fifo_data_i into the shift register, compute parity from it, and enter START next cycle.
REQ-017 SHALL hold each bit on tx_o for exactly CLKS_PER_BIT cycles, using a bit-time counter of width $clog2(CLKS_PER_BIT) that reloads at each bit boundary.
REQ-018 SHALL drive tx_o as follows: START 0; DATA LSB first, DATA_BITS bits; PARITY bit; STOP 1 for STOP_BITS bit times.
REQ-019 SHALL drive the parity bit as XOR of the data bits for even parity and its inverse for odd parity.
REQ-020 SHALL make frame length (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles.
REQ-021 SHALL, on the last cycle of the last stop bit, go to START if pop occurs (back-to-back frames with no idle gap) and otherwise go to IDLE.
REQ-022 SHALL make the first START cycle follow the pop cycle by exactly 1 cycle (latency pop->start edge of tx_o = 1).
REQ-023 SHALL make busy_o high from the first START cycle through the last STOP cycle and low in IDLE.
REQ-024 SHALL, when tx_en_i deasserts mid-frame, finish the current frame and pop nothing further.
REQ-025 SHALL ignore fifo_data_i changes outside the pop cycle.

Reset
REQ-026 SHALL, while rst_i=1, set state IDLE, tx_o=1, busy_o=0, fifo_rd_en_o=0, and counters to 0.
REQ-027 SHALL, on rst_i asserted mid-frame, abort the frame, bring tx_o high on the next cycle, and leave the word already popped lost (no re-read).
REQ-028 SHALL, on the first cycle after reset release with fifo_empty_i=0 and tx_en_i=1, pop in that cycle.

Verification
REQ-029 SHALL cover single byte: DATA_BITS=8, CLKS_PER_BIT=4, PARITY=0, FIFO holds 0xA5 -> one rd_en pulse, then tx_o = 0 for 4 cycles, data bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1; busy_o high exactly 40 cycles.
REQ-030 SHALL cover back-to-back: FIFO holds 0x00,0xFF -> second rd_en in the last stop cycle of frame 1, second START on the immediately following cycle, busy_o never drops across the boundary (80 cycles).
REQ-031 SHALL cover parity: PARITY=2 with 0x07 -> parity bit 1; PARITY=1 with 0x07 -> parity bit 0; frame 44 cycles at CLKS_PER_BIT=4.
REQ-032 SHALL cover empty and disabled: fifo_empty_i=1 or tx_en_i=0 for 100 cycles -> fifo_rd_en_o stays 0, tx_o stays 1, busy_o stays 0.
REQ-033 SHALL cover disable mid-frame: tx_en_i dropped at data bit 3 with FIFO non-empty -> frame completes intact, no further rd_en, return to IDLE.
REQ-034 SHALL cover reset mid-frame: rst_i pulsed during DATA -> next cycle tx_o=1, busy_o=0; after release the next FIFO word is popped immediately, not the aborted one.
